// File: rtl/rv_pkg.sv
// Shared RISC-V encoding constants for the branch path.
package rv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        COND_BEQ  = 3'b000,
        COND_BNE  = 3'b001,
        COND_BLT  = 3'b100,
        COND_BGE  = 3'b101,
        COND_BLTU = 3'b110,
        COND_BGEU = 3'b111
    } branch_cond_t;

    // True when the opcode field selects a conditional branch.
    function automatic logic is_branch_opcode(input logic [6:0] op);
        return op == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational B-type condition evaluator. funct3 encodings 010/011 are
// reserved and flagged via illegal_f3 with taken forced low.
module branch_cmp
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            illegal_f3
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Select the comparison named by funct3; signed forms use the _s copies.
    always_comb begin
        taken      = 1'b0;
        illegal_f3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = (a_s <  b_s);
            F3_BGE:  taken = (a_s >= b_s);
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: illegal_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: condition evaluation, target and
// redirect computation, misprediction check, one-deep valid/ready output
// register and saturating retire statistics.
module branch_resolve_unit
    import rv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OFFW = 12,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] pc,
    input  logic [OFFW-1:0] addr,
    input  logic            pred_taken,
    input  logic            flush,
    input  logic            clear_stats,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal,
    output logic [CNTW-1:0] branch_count,
    output logic [CNTW-1:0] mispredict_count
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v,
                                                input logic            inc);
        if (inc && (v != {CNTW{1'b1}})) begin
            return v + CNTW'(1);
        end
        return v;
    endfunction

    logic                   cmp_taken;
    logic                   cmp_illegal_f3;
    logic                   illegal_p0;
    logic                   taken_p0;
    logic                   mispredict_p0;
    logic signed [XLEN-1:0] off_p0;
    logic        [XLEN-1:0] target_p0;
    logic        [XLEN-1:0] seq_pc_p0;
    logic        [XLEN-1:0] redirect_p0;

    logic                   vld_p1;
    logic                   taken_p1;
    logic                   mispredict_p1;
    logic                   illegal_p1;
    logic        [XLEN-1:0] target_p1;
    logic        [XLEN-1:0] redirect_p1;

    logic        [CNTW-1:0] branch_cnt_q;
    logic        [CNTW-1:0] mispredict_cnt_q;

    logic                   accept;
    logic                   retire;

    // in_ready only looks at flush, out_ready and the register's own state,
    // so there is no path from the request inputs back to in_ready.
    assign in_ready = !flush && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = vld_p1 && out_ready && !flush && !illegal_p1;

    // ---- stage p0: combinational resolve of the incoming request ----
    branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .funct3     (funct3),
        .a          (A),
        .b          (B),
        .taken      (cmp_taken),
        .illegal_f3 (cmp_illegal_f3)
    );

    // Resolve direction, target and redirect; targets wrap modulo 2^XLEN.
    always_comb begin
        illegal_p0    = !is_branch_opcode(opcode) || cmp_illegal_f3;
        taken_p0      = cmp_taken && !illegal_p0;
        mispredict_p0 = !illegal_p0 && (taken_p0 != pred_taken);
        off_p0        = {{(XLEN-OFFW){addr[OFFW-1]}}, addr};
        target_p0     = pc + $unsigned(off_p0 <<< 1);
        seq_pc_p0     = pc + XLEN'(4);
        redirect_p0   = taken_p0 ? target_p0 : seq_pc_p0;
    end

    // ---- stage p1: output register ----
    // Valid tracks accept/drain/flush; payload loads only on accept so it
    // holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            taken_p1      <= 1'b0;
            mispredict_p1 <= 1'b0;
            illegal_p1    <= 1'b0;
            target_p1     <= '0;
            redirect_p1   <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept) begin
                vld_p1 <= 1'b1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (accept) begin
                taken_p1      <= taken_p0;
                mispredict_p1 <= mispredict_p0;
                illegal_p1    <= illegal_p0;
                target_p1     <= target_p0;
                redirect_p1   <= redirect_p0;
            end
        end
    end

    // Retire statistics; clear_stats wins over a same-cycle retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (clear_stats) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (retire) begin
            branch_cnt_q     <= sat_inc(branch_cnt_q, 1'b1);
            mispredict_cnt_q <= sat_inc(mispredict_cnt_q, mispredict_p1);
        end
    end

    assign out_valid        = vld_p1;
    assign taken            = taken_p1;
    assign target           = target_p1;
    assign mispredict       = mispredict_p1;
    assign redirect_pc      = redirect_p1;
    assign illegal          = illegal_p1;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (XLEN=64, OFFW=12, CNTW=4).
module tb_branch_resolve_unit;

    localparam int XLEN = 64;
    localparam int OFFW = 12;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;
    localparam logic [6:0] BR = 7'b1100011;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] pc;
    logic [OFFW-1:0] addr;
    logic            pred_taken;
    logic            flush;
    logic            clear_stats;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal;
    logic [CNTW-1:0] branch_count;
    logic [CNTW-1:0] mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN(XLEN),
        .OFFW(OFFW),
        .CNTW(CNTW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .opcode           (opcode),
        .funct3           (funct3),
        .A                (A),
        .B                (B),
        .pc               (pc),
        .addr             (addr),
        .pred_taken       (pred_taken),
        .flush            (flush),
        .clear_stats      (clear_stats),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .taken            (taken),
        .target           (target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .illegal          (illegal),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
        logic [XLEN-1:0] redirect;
        logic            illegal;
    } exp_t;

    exp_t q[$];
    int   m_bc = 0;
    int   m_mc = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the instruction-set definition.
    function automatic exp_t model_eval(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                        input logic [XLEN-1:0] p, input logic [OFFW-1:0] ad,
                                        input logic pr);
        exp_t e;
        logic signed [OFFW-1:0] ad_s;
        longint off;
        bit legal;
        bit cond;
        ad_s  = ad;
        off   = ad_s;
        legal = (op == BR) && (f3 != 3'd2) && (f3 != 3'd3);
        case (f3)
            3'd0:    cond = (a == b);
            3'd1:    cond = (a != b);
            3'd4:    cond = ($signed(a) <  $signed(b));
            3'd5:    cond = ($signed(a) >= $signed(b));
            3'd6:    cond = (a <  b);
            3'd7:    cond = (a >= b);
            default: cond = 1'b0;
        endcase
        e.target     = p + XLEN'(off * 2);
        e.taken      = legal && cond;
        e.mispredict = legal && (e.taken != pr);
        e.redirect   = e.taken ? e.target : p + 64'd4;
        e.illegal    = !legal;
        return e;
    endfunction

    // Model: a queue of at most one held result plus two integer counters.
    initial begin : model
        bit rdy;
        bit ret;
        bit pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_bc = 0;
                m_mc = 0;
            end else begin
                rdy = !flush && (q.size() == 0 || out_ready);
                ret = (q.size() != 0) && out_ready && !flush && !q[0].illegal;
                pop = (q.size() != 0) && out_ready;
                if (clear_stats) begin
                    m_bc = 0;
                    m_mc = 0;
                end else if (ret) begin
                    if (m_bc < CMAX) m_bc++;
                    if (q[0].mispredict && m_mc < CMAX) m_mc++;
                end
                if (flush) q.delete();
                else if (pop) void'(q.pop_front());
                if (in_valid && rdy)
                    q.push_back(model_eval(opcode, funct3, A, B, pc, addr, pred_taken));
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", in_ready, !flush && (q.size() == 0 || out_ready));
                chk("out_valid", out_valid, q.size() != 0);
                if (q.size() != 0 && out_valid) begin
                    chk("taken", taken, q[0].taken);
                    chk("target", target, q[0].target);
                    chk("mispredict", mispredict, q[0].mispredict);
                    chk("redirect_pc", redirect_pc, q[0].redirect);
                    chk("illegal", illegal, q[0].illegal);
                end
                chk("branch_count", branch_count, m_bc);
                chk("mispredict_count", mispredict_count, m_mc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] p, input logic [OFFW-1:0] ad,
                         input logic pr);
        opcode     = op;
        funct3     = f3;
        A          = a;
        B          = b;
        pc         = p;
        addr       = ad;
        pred_taken = pr;
        in_valid   = 1'b1;
    endtask

    initial begin : stim
        logic [2:0] f3s [4];
        logic       exps[4];
        logic       pat [4];
        int idx;
        int cyc;

        rst_n = 1'b0;
        in_valid = 1'b0;
        opcode = '0; funct3 = '0; A = '0; B = '0; pc = '0; addr = '0;
        pred_taken = 1'b0; flush = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_taken", taken, 1'b0);
        chk("rst_target", target, 64'h0);
        chk("rst_redirect", redirect_pc, 64'h0);
        chk("rst_mispredict", mispredict, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_bc", branch_count, 4'd0);
        chk("rst_mc", mispredict_count, 4'd0);
        rst_n = 1'b1;
        tick();

        // BEQ taken, predicted not-taken; held one cycle then retired.
        drive(BR, 3'b000, 64'd100, 64'd100, 64'h1000, 12'h008, 1'b0);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_taken", taken, 1'b1);
        chk("t1_target", target, 64'h1010);
        chk("t1_mispredict", mispredict, 1'b1);
        chk("t1_redirect", redirect_pc, 64'h1010);
        out_ready = 1'b1;
        tick();
        chk("t1_mc", mispredict_count, 4'd1);
        chk("t1_bc", branch_count, 4'd1);

        // Signed vs unsigned with A = -1, B = 1.
        f3s[0] = 3'b100; exps[0] = 1'b1;
        f3s[1] = 3'b110; exps[1] = 1'b0;
        f3s[2] = 3'b111; exps[2] = 1'b1;
        f3s[3] = 3'b101; exps[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(BR, f3s[i], {XLEN{1'b1}}, 64'd1, 64'h200, 12'h010, 1'b0);
            tick();
            chk($sformatf("t2_taken_f3_%0d", f3s[i]), taken, exps[i]);
        end
        in_valid = 1'b0;
        tick();

        // Negative offset, BNE taken then not taken.
        drive(BR, 3'b001, 64'd42, 64'd43, 64'h100, 12'hFF8, 1'b1);
        tick();
        chk("t3_taken", taken, 1'b1);
        chk("t3_target", target, 64'hF0);
        drive(BR, 3'b001, 64'd42, 64'd42, 64'h100, 12'hFF8, 1'b1);
        tick();
        chk("t3_nt_taken", taken, 1'b0);
        chk("t3_nt_redirect", redirect_pc, 64'h104);
        chk("t3_nt_target", target, 64'hF0);
        in_valid = 1'b0;
        tick();
        chk("t3_bc", branch_count, 4'd7);
        chk("t3_mc", mispredict_count, 4'd4);

        // Four back-to-back requests with out_ready pattern 1,0,0,1.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            drive(BR, 3'b000, 64'(idx), 64'(idx), 64'h3000 + 64'(idx * 16), 12'h004, 1'b1);
            out_ready = pat[cyc % 4];
            @(negedge clk);
            if (in_ready) idx++;
            tick();
            cyc++;
        end
        chk("t4_accepts", idx, 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("t4_bc", branch_count, 4'd11);
        chk("t4_mc", mispredict_count, 4'd4);

        // Flush while FULL with out_ready high.
        drive(BR, 3'b000, 64'd5, 64'd5, 64'h400, 12'h004, 1'b1);
        out_ready = 1'b0;
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(BR, 3'b000, 64'd6, 64'd6, 64'h480, 12'h004, 1'b1);
        #1;
        chk("t5_flush_in_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_valid", out_valid, 1'b0);
        chk("t5_flush_bc", branch_count, 4'd11);

        // Asynchronous reset with an entry held.
        drive(BR, 3'b000, 64'd5, 64'd6, 64'h400, 12'h004, 1'b1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t5_held", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_bc", branch_count, 4'd0);
        chk("t5_rst_mc", mispredict_count, 4'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Illegal opcode and reserved funct3.
        drive(7'h33, 3'b000, 64'd9, 64'd9, 64'h500, 12'h002, 1'b1);
        tick();
        chk("t6_op_illegal", illegal, 1'b1);
        chk("t6_op_taken", taken, 1'b0);
        chk("t6_op_mispredict", mispredict, 1'b0);
        chk("t6_op_target", target, 64'h504);
        drive(BR, 3'b010, 64'd9, 64'd9, 64'h500, 12'h002, 1'b1);
        tick();
        chk("t6_f3_illegal", illegal, 1'b1);
        chk("t6_f3_taken", taken, 1'b0);
        chk("t6_f3_redirect", redirect_pc, 64'h504);
        in_valid = 1'b0;
        tick();
        chk("t6_bc", branch_count, 4'd0);
        chk("t6_mc", mispredict_count, 4'd0);

        // Saturation: 16 mispredicted retires into 4-bit counters.
        for (int i = 0; i < 16; i++) begin
            drive(BR, 3'b000, 64'd1, 64'd2, 64'h800, 12'h002, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_sat_bc", branch_count, 4'd15);
        chk("t6_sat_mc", mispredict_count, 4'd15);

        // clear_stats coinciding with a retire.
        drive(BR, 3'b000, 64'd3, 64'd3, 64'h600, 12'h002, 1'b0);
        tick();
        in_valid = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("t6_clr_bc", branch_count, 4'd0);
        chk("t6_clr_mc", mispredict_count, 4'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered branch-resolution stage for the pipelined RISC-V core, successor to the combinational BEQ-only compare path in the ALU. Evaluates all six B-type conditions (BEQ, BNE, BLT, BGE, BLTU, BGEU) at width XLEN and computes the branch target. Checks the result against the fetch-stage prediction and drives the redirect PC. Sits between the EX operand muxes and the fetch redirect logic, with a one-deep valid/ready pipeline register and saturating branch/mispredict statistics counters.

## Interface
- XLEN, 64: operand and PC width.
- OFFW, 12: branch offset width; the offset is imm[12:1], signed, in halfwords.
- CNTW, 32: statistics counter width.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- opcode  in  7  instruction opcode.
- funct3  in  3  branch condition.
- A, B  in  XLEN each  rs1 and rs2 operands, two's complement.
- pc  in  XLEN  PC of the branch.
- addr  in  OFFW  signed halfword offset.
- pred_taken  in  1  fetch-stage prediction.
- flush  in  1  kill the held entry and block acceptance this cycle.
- clear_stats  in  1  synchronous zero of both counters.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  resolved direction.
- target  out  XLEN  pc + (sext(addr) << 1), modulo 2^XLEN.
- mispredict  out  1  taken != pred_taken for a legal branch.
- redirect_pc  out  XLEN  target if taken, else pc + 4.
- illegal  out  1  opcode is not 1100011, or funct3 is 010 or 011.
- branch_count  out  CNTW  retired legal branches.
- mispredict_count  out  CNTW  retired mispredicts.

## Operation
- Conditions:
  - funct3 000: A==B.
  - 001: A!=B.
  - 100: signed A<B.
  - 101: signed A>=B.
  - 110: unsigned A<B.
  - 111: unsigned A>=B.
- Illegal requests are still accepted. They produce illegal=1, taken=0 and mispredict=0, with target and redirect_pc computed as usual. They are not counted.
- Arithmetic: target and pc+4 wrap modulo 2^XLEN with no flag. The offset is sign-extended from bit OFFW-1 before the shift.
- Pipeline register states:
  - EMPTY (out_valid=0) goes to FULL on accept.
  - FULL with out_ready=1 stays FULL if a new request is accepted in the same cycle, otherwise returns to EMPTY.
  - FULL with out_ready=0 holds, and all outputs stay stable.
- in_ready = !flush && (!out_valid || out_ready). A request is accepted when in_valid && in_ready.
- flush: out_valid goes to 0 next cycle. The held entry is discarded and never counted, even if out_ready=1 in the flush cycle. No request is accepted that cycle.
- Counters update on retire (out_valid && out_ready && !flush && !illegal):
  - branch_count += 1.
  - mispredict_count += mispredict.
  - Both saturate at 2^CNTW-1.
- clear_stats has priority over a same-cycle increment; the counters are 0 next cycle.

## Timing
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Reset values: out_valid=0; taken, mispredict, illegal, target, redirect_pc = 0; both counters 0. in_ready reads 1 during reset as long as flush=0.
- Reset asserted mid-operation drops the held entry immediately and asynchronously, with no retire count.
- Data outputs are registered, qualified by out_valid, and unchanged while out_valid && !out_ready.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready and flush only.

## Structure
- The shared package rv_pkg holds:
  - OPC_BRANCH = 7'b1100011.
  - The funct3 localparams F3_BEQ..F3_BGEU.
  - A branch_cond_t enum.
- Sub-module branch_cmp holds the purely combinational condition evaluator, parametrised by XLEN. It takes funct3, A and B and returns taken and illegal_f3, and is reused by a future compressed-branch path.
- The top level holds the pipeline register, the target and redirect adders, and the counters.

## Test plan
- XLEN=64, BEQ, A=B=100, pc=0x1000, addr=0x008, pred_taken=0 -> after 1 cycle: taken=1, target=0x1010, mispredict=1, redirect_pc=0x1010, mispredict_count=1 on retire.
- BLT vs BLTU with A=-1 (all ones), B=1 -> BLT taken=1, BLTU taken=0. BGEU taken=1, BGE taken=0.
- addr=0xFF8 (-8 halfwords), pc=0x100, BNE with A=42, B=43 -> taken=1, target=0xF0. BNE with A=B=42 -> redirect_pc=0x104.
- Back-to-back 4 requests with out_ready toggling 1,0,0,1 -> outputs stable while stalled, no loss or duplication, branch_count=4.
- flush while FULL with out_ready=1 -> out_valid=0 next cycle, counter unchanged, in_ready=0 in the flush cycle. Also rst_n pulsed low mid-stream -> out_valid=0 immediately, counters 0.
- opcode=0x33 or funct3=010 -> illegal=1, taken=0, not counted. Also preload branch_count to 2^CNTW-1 with CNTW=4 -> it saturates at 15, and clear_stats on a retire cycle gives 0.
